// File: rtl/cc_param.sv
// Cross-correlation lag search: accumulates corr[k] for k = -MAX_LAG..+MAX_LAG over one frame and reports the peak lag.
// Optional macro CC_PARAM_ABS_PEAK_EN ranks lags by |corr[k]| instead of signed corr[k].
module cc_param #(
    parameter int DATA_W    = 16,
    parameter int N_SAMPLES = 12800,
    parameter int MAX_LAG   = 32,
    parameter int ACC_W     = 48,
    parameter int LAG_W     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] m0,
    input  logic signed [DATA_W-1:0] m1,
    output logic [LAG_W-1:0]         index,
    output logic [ACC_W-1:0]         peak,
    output logic                     busy,
    output logic                     done
);
    localparam int TAPS  = 2*MAX_LAG + 1;
    localparam int SEL_W = $clog2(TAPS);
    localparam int CNT_W = $clog2(N_SAMPLES + TAPS + 1);
    localparam int PW    = 2*DATA_W;

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, SCAN, DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0]         cnt;
    logic signed [DATA_W-1:0] dly [MAX_LAG];
    logic signed [DATA_W-1:0] win [TAPS];
    logic signed [DATA_W-1:0] win_nx [TAPS];
    logic signed [PW-1:0]     prod [TAPS];
    logic signed [ACC_W-1:0]  acc [TAPS];
    logic signed [ACC_W-1:0]  best_val;
    logic [LAG_W-1:0]         best_idx;

    logic                     accept, shift, last_sample, flush_end, scan_end, start_ok;
    logic signed [DATA_W-1:0] in0, in1;
    logic signed [PW-1:0]     d_ext;
    logic [SEL_W-1:0]         sel;
    logic signed [ACC_W-1:0]  cand;
    logic [LAG_W-1:0]         cand_idx;
    logic                     better, take;

    assign accept      = (state == LOAD) && in_valid;
    assign shift       = accept || (state == FLUSH);
    assign last_sample = accept && (cnt == CNT_W'(N_SAMPLES - 1));
    assign flush_end   = (state == FLUSH) && (cnt == CNT_W'(MAX_LAG - 1));
    assign scan_end    = (state == SCAN) && (cnt == CNT_W'(TAPS - 1));
    assign start_ok    = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    begin
                         in_ready = 1'b1;
                         busy     = 1'b1;
                         if (last_sample) state_nx = FLUSH;
                     end
            FLUSH:   begin
                         busy = 1'b1;
                         if (flush_end) state_nx = SCAN;
                     end
            SCAN:    begin
                         busy = 1'b1;
                         if (scan_end) state_nx = DONE;
                     end
            DONE:    begin
                         done = 1'b1;
                         if (start) state_nx = LOAD;
                     end
            default: state_nx = IDLE;
        endcase
    end

    // The sample leaving the delay line is m0[t-MAX_LAG]; window tap j holds m1[t-j], so tap j feeds lag MAX_LAG-j.
    always_comb begin
        in0   = (state == LOAD) ? m0 : '0;
        in1   = (state == LOAD) ? m1 : '0;
        d_ext = {{DATA_W{dly[MAX_LAG-1][DATA_W-1]}}, dly[MAX_LAG-1]};
        for (int unsigned j = 0; j < TAPS; j++) begin
            win_nx[j] = (j == 0) ? in1 : win[j-1];
            prod[j]   = d_ext * {{DATA_W{win_nx[j][DATA_W-1]}}, win_nx[j]};
        end
    end

    always_comb begin
        sel      = cnt[SEL_W-1:0];
        cand     = acc[sel];
        cand_idx = LAG_W'(sel) - LAG_W'(MAX_LAG);
`ifdef CC_PARAM_ABS_PEAK_EN
        begin
            logic [ACC_W-1:0] cand_m, best_m;
            cand_m = cand[ACC_W-1] ? -cand : cand;
            best_m = best_val[ACC_W-1] ? -best_val : best_val;
            better = cand_m > best_m;
        end
`else
        better = cand > best_val;
`endif
        take = (cnt == '0) || better;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            best_val <= '0;
            best_idx <= '0;
            index    <= '0;
            peak     <= '0;
            for (int unsigned i = 0; i < MAX_LAG; i++) dly[i] <= '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                win[i] <= '0;
                acc[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (start_ok) begin
                cnt <= '0;
                for (int unsigned i = 0; i < MAX_LAG; i++) dly[i] <= '0;
                for (int unsigned i = 0; i < TAPS; i++) begin
                    win[i] <= '0;
                    acc[i] <= '0;
                end
            end else begin
                if (shift) begin
                    dly[0] <= in0;
                    for (int unsigned i = 1; i < MAX_LAG; i++) dly[i] <= dly[i-1];
                    for (int unsigned i = 0; i < TAPS; i++) begin
                        win[i] <= win_nx[i];
                        acc[i] <= acc[i] + {{(ACC_W-PW){prod[TAPS-1-i][PW-1]}}, prod[TAPS-1-i]};
                    end
                end
                if (last_sample || flush_end || scan_end)
                    cnt <= '0;
                else if (accept || (state == FLUSH) || (state == SCAN))
                    cnt <= cnt + CNT_W'(1);
                if (state == SCAN) begin
                    if (take) begin
                        best_val <= cand;
                        best_idx <= cand_idx;
                    end
                    if (scan_end) begin
                        index <= take ? cand_idx : best_idx;
                        peak  <= take ? cand : best_val;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cc_param.sv
// Scoreboard bench for cc_param: frames are queued with model/hand expectations, a monitor checks each done rise.
module tb_cc_param;
    localparam int DW = 16, NS = 256, ML = 32, AW = 48, LW = 10;
    localparam int NONE = 999;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, busy, done;
    logic signed [DW-1:0] m0, m1;
    logic [LW-1:0] index;
    logic [AW-1:0] peak;

    always #5 clk = ~clk;

    cc_param #(.DATA_W(DW), .N_SAMPLES(NS), .MAX_LAG(ML), .ACC_W(AW), .LAG_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .m0(m0), .m1(m1), .index(index), .peak(peak), .busy(busy), .done(done)
    );

    typedef struct { string name; int idx; longint pk; } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    int n_vec = 0, n_bad = 0;
    int last_idx = 0;
    longint last_pk = 0;
    logic signed [DW-1:0] m0a [NS];
    logic signed [DW-1:0] m1a [NS];
    logic signed [DW-1:0] xs [NS+ML];

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.name, "_index"}, longint'($signed(index)), longint'(mon_e.idx));
                check({mon_e.name, "_peak"}, longint'($signed(peak)), mon_e.pk);
            end
        end
        done_q <= done;
    end

    // Direct definition of the correlation, independent of the shift-register structure.
    function automatic void model(output int bi, output longint bp);
        longint c, met, bm;
        bi = -ML; bp = 0; bm = 0;
        for (int k = -ML; k <= ML; k++) begin
            c = 0;
            for (int n = 0; n < NS; n++)
                if (n + k >= 0 && n + k < NS)
                    c += longint'(m0a[n]) * longint'(m1a[n+k]);
`ifdef CC_PARAM_ABS_PEAK_EN
            met = (c < 0) ? -c : c;
`else
            met = c;
`endif
            if (k == -ML || met > bm) begin
                bm = met; bi = k; bp = c;
            end
        end
    endfunction

    task automatic fill_random();
        int v;
        for (int n = 0; n < NS + ML; n++) begin
            v = int'($urandom_range(2000)) - 1000;
            xs[n] = DW'(v);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_frame(input string nm, input int gap, input int mid_start, input int hand_idx);
        int mi, i, cyc, w;
        longint mp;
        exp_t e;
        model(mi, mp);
        e.name = nm;
        e.idx  = (hand_idx != NONE) ? hand_idx : mi;
        e.pk   = mp;
        sbq.push_back(e);
        pulse_start();
        check({nm, "_busy_load"}, longint'(busy), 1);
        check({nm, "_peak_held"}, longint'($signed(peak)), last_pk);
        i = 0; cyc = 0;
        while (i < NS && cyc < 8*NS) begin
            in_valid = (gap != 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            start    = (mid_start != 0) && (cyc == 50);
            m0 = m0a[i];
            m1 = m1a[i];
            @(posedge clk);
            if (in_valid && in_ready) i++;
            #1 cyc++;
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (i < NS) check({nm, "_feed_timeout"}, i, NS);
        w = 0;
        while (!done && w < 1000) begin
            @(posedge clk); #1 w++;
        end
        if (!done) begin
            check({nm, "_done_timeout"}, 0, 1);
            sbq.delete();
        end else if (gap == 0 && mid_start == 0) begin
            check({nm, "_latency"}, cyc + w, NS + ML + 2*ML + 1);
        end
        repeat (3) @(posedge clk);
        #1 check({nm, "_done_hold"}, longint'(done), 1);
        check({nm, "_ready_idle"}, longint'(in_ready), 0);
        last_idx = e.idx;
        last_pk  = e.pk;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int i;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; m0 = '0; m1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_ready", longint'(in_ready), 0);
        check("rst_index", longint'(index), 0);
        check("rst_peak", longint'(peak), 0);

        for (int n = 0; n < NS; n++) begin
            m0a[n] = DW'($rtoi(1000.0 * $sin(2.0 * 3.14159265358979 * n / 32.0)));
            m1a[n] = m0a[n];
        end
        run_frame("sine_same", 0, 0, 0);

        fill_random();
        for (int n = 0; n < NS; n++) begin m0a[n] = xs[n+25]; m1a[n] = xs[n]; end
        run_frame("lag_pos25", 0, 0, 25);

        for (int n = 0; n < NS; n++) begin m0a[n] = xs[n]; m1a[n] = xs[n+25]; end
        run_frame("lag_neg25", 0, 0, -25);

        for (int n = 0; n < NS; n++) begin m0a[n] = xs[n]; m1a[n] = -xs[n]; end
`ifdef CC_PARAM_ABS_PEAK_EN
        run_frame("negated", 0, 0, 0);
`else
        run_frame("negated", 0, 0, NONE);
`endif

        for (int n = 0; n < NS; n++) begin m0a[n] = '0; m1a[n] = '0; end
        run_frame("all_zero", 0, 0, -ML);

        // Abort a frame at its 100th sample, then run a clean frame.
        fill_random();
        for (int n = 0; n < NS; n++) begin m0a[n] = xs[n]; m1a[n] = xs[n+7]; end
        pulse_start();
        i = 0;
        while (i < 100) begin
            in_valid = 1'b1;
            m0 = m0a[i]; m1 = m1a[i];
            rst = (i == 99);
            @(posedge clk); #1 i++;
        end
        rst = 1'b0; in_valid = 1'b0;
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_ready", longint'(in_ready), 0);
        check("abort_index", longint'(index), 0);
        check("abort_peak", longint'(peak), 0);
        last_idx = 0; last_pk = 0;
        for (int n = 0; n < NS; n++) m1a[n] = m0a[n];
        run_frame("after_abort", 0, 0, 0);

        for (int n = 0; n < NS; n++) begin m0a[n] = xs[n+25]; m1a[n] = xs[n]; end
        run_frame("gaps_midstart", 1, 1, 25);

        repeat (2) @(posedge clk);
        if (sbq.size() != 0) check("scoreboard_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cc_param.md
CC_PARAM -- requirements
Module: cc_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, signed sample width of m0/m1.
REQ-002 SHALL provide parameter N_SAMPLES, default 12800, samples per correlation frame.
REQ-003 SHALL provide parameter MAX_LAG, default 32, lag search range -MAX_LAG..+MAX_LAG.
REQ-004 SHALL provide parameter ACC_W, default 48, signed accumulator width.
REQ-005 SHALL provide parameter LAG_W, default 10, signed width of index.
REQ-006 SHALL have the port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have the port rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have the port start, input, 1, a one-cycle pulse that begins a frame.
REQ-009 SHALL have the port in_valid, input, 1, meaning m0/m1 carry a sample pair.
REQ-010 SHALL have the port in_ready, output, 1, meaning a sample pair is accepted this cycle.
REQ-011 SHALL have the ports m0 and m1, input, DATA_W each, signed samples of channels 0 and 1.
REQ-012 SHALL have the port index, output, LAG_W, the signed lag of the correlation peak.
REQ-013 SHALL have the port peak, output, ACC_W, the accumulator value at the winning lag.
REQ-014 SHALL have the ports busy and done, output, 1 each, frame in progress and result valid.

Function
REQ-015 SHALL compute corr[k] = sum over n of m0[n]*m1[n+k] for k = -MAX_LAG..+MAX_LAG, with out-of-frame samples treated as zero.
REQ-016 SHALL implement the states IDLE, LOAD, FLUSH, SCAN and DONE.
REQ-017 SHALL, in IDLE or DONE, on start=1 clear all 2*MAX_LAG+1 accumulators, zero the m0 delay line and the m1 window, clear the sample counter, drop done and enter LOAD.
REQ-018 SHALL ignore start in LOAD, FLUSH and SCAN.
REQ-019 SHALL assert in_ready only in LOAD and count a sample only when in_valid && in_ready; in_valid gaps of any length SHALL be tolerated without affecting the result.
REQ-020 SHALL, per accepted sample, shift m0 into a MAX_LAG-deep delay line and m1 into a 2*MAX_LAG+1 window, and add delayed_m0 * window tap into each lag accumulator in parallel.
REQ-021 SHALL enter FLUSH after the N_SAMPLES-th accepted sample and feed exactly MAX_LAG zero sample pairs, one per cycle.
REQ-022 SHALL then enter SCAN and visit lags -MAX_LAG up to +MAX_LAG, one per cycle, for 2*MAX_LAG+1 cycles.
REQ-023 SHALL replace the running best only on strictly greater comparison, so on a tie the most negative lag wins.
REQ-024 SHALL then enter DONE, present index and peak, and hold done=1 until the next start or rst.
REQ-025 SHALL assert busy exactly in LOAD, FLUSH and SCAN.
REQ-026 SHALL sign-extend products to ACC_W and wrap modulo 2^ACC_W on overflow; ACC_W >= 2*DATA_W + clog2(N_SAMPLES) guarantees no wrap.
REQ-027 SHALL hold index and peak stable outside DONE at their last values, or at reset values if no frame has completed.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, enter IDLE and set in_ready=0, busy=0, done=0, index=0, peak=0, clearing all accumulators.
REQ-029 SHALL abort any in-progress frame on rst; rst takes priority over a simultaneous start.

Configuration
REQ-030 SHALL, with macro CC_PARAM_ABS_PEAK_EN defined, rank lags by |corr[k]| and report peak as the signed value at the winner.
REQ-031 SHALL, without CC_PARAM_ABS_PEAK_EN, rank lags by signed corr[k].

Verification
REQ-032 SHALL cover, with N_SAMPLES=256 and MAX_LAG=32, m1 = m0 (sine, amplitude 1000) -> index=0, done after 256 samples + 32 + 65 cycles.
REQ-033 SHALL cover m1[n] = m0[n-25] on a random sequence -> index=+25; and m1[n] = m0[n+25] -> index=-25.
REQ-034 SHALL cover m1 = -m0 with a random sequence -> index=0 with peak<0 under CC_PARAM_ABS_PEAK_EN; without it, index is not 0 and peak is the maximum signed corr.
REQ-035 SHALL cover all-zero inputs -> tie everywhere, index=-32, peak=0.
REQ-036 SHALL cover rst at the 100th accepted sample, then a fresh start with m1=m0 -> index=0, with no residue from the aborted frame.
REQ-037 SHALL cover in_valid toggling 1-0-0-1 through the frame and start pulsed mid-LOAD -> same index as the gap-free run, and start ignored.
